// File: rtl/wide_operand_loader.sv
// wide_operand_loader: builds a pair of WORD_WIDTH-bit operands (A then B)
// from a narrow stream of STEP_WORD_WIDTH-bit words, least-significant word
// first, and offers the finished pair downstream. A pair must end with
// input_last on its final B word. A pair that ends early, or that runs past
// its final B word without input_last, is thrown away and framing_error
// pulses once.
//
// Handshakes: a word moves when input_valid && input_ready && clock_enable.
// A pair moves when output_valid && output_ready && clock_enable.
// input_ready depends only on the state register. It never depends on
// input_valid or output_ready.
module wide_operand_loader #(
    parameter int WORD_WIDTH      = 32,
    parameter int STEP_WORD_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       clock_enable,
    input  logic                       input_valid,
    output logic                       input_ready,
    input  logic [STEP_WORD_WIDTH-1:0] input_data,
    input  logic                       input_last,
    output logic                       output_valid,
    input  logic                       output_ready,
    output logic [WORD_WIDTH-1:0]      A,
    output logic [WORD_WIDTH-1:0]      B,
    output logic                       framing_error,
    output logic [1:0]                 debug_state
);

    localparam int STEP_COUNT = (WORD_WIDTH + STEP_WORD_WIDTH - 1) / STEP_WORD_WIDTH;
    localparam int CW         = (STEP_COUNT > 1) ? $clog2(STEP_COUNT) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEP_COUNT - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        OUTPUT = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          accept;
    logic [WORD_WIDTH-1:0] a_next;
    logic [WORD_WIDTH-1:0] b_next;

    assign input_ready = (state != OUTPUT);
    assign accept      = input_valid && input_ready;
    assign debug_state = state;

    // Merge the incoming word into the slice selected by count. Bits that
    // would land at or above WORD_WIDTH have no target, so they drop out.
    always_comb begin
        a_next = A;
        b_next = B;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (int'(count) == (i / STEP_WORD_WIDTH)) begin
                a_next[i] = input_data[i % STEP_WORD_WIDTH];
                b_next[i] = input_data[i % STEP_WORD_WIDTH];
            end
        end
    end

    // Framing FSM, operand registers and registered handshake/status outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state         <= LOAD_A;
            count         <= '0;
            A             <= '0;
            B             <= '0;
            output_valid  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            if (clock_enable) begin
                case (state)
                    LOAD_A: begin
                        if (accept) begin
                            A <= a_next;
                            if (input_last) begin
                                // Last marker arrived inside A, so the pair is short.
                                framing_error <= 1'b1;
                                count         <= '0;
                                state         <= LOAD_A;
                            end else if (count == LAST_COUNT) begin
                                count <= '0;
                                state <= LOAD_B;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (accept) begin
                            B <= b_next;
                            if (count == LAST_COUNT) begin
                                count <= '0;
                                if (input_last) begin
                                    output_valid <= 1'b1;
                                    state        <= OUTPUT;
                                end else begin
                                    state <= DRAIN;
                                end
                            end else if (input_last) begin
                                framing_error <= 1'b1;
                                count         <= '0;
                                state         <= LOAD_A;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        // Discard words until the stream resynchronises on a last marker.
                        if (accept && input_last) begin
                            framing_error <= 1'b1;
                            count         <= '0;
                            state         <= LOAD_A;
                        end
                    end
                    OUTPUT: begin
                        if (output_ready) begin
                            output_valid <= 1'b0;
                            count        <= '0;
                            state        <= LOAD_A;
                        end
                    end
                    default: begin
                        state <= LOAD_A;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wide_operand_loader.sv
// Directed testbench for wide_operand_loader with WORD_WIDTH=20 and
// STEP_WORD_WIDTH=8, so each operand takes three words.
module tb_wide_operand_loader;

    localparam int WW = 20;
    localparam int SW = 8;

    logic          clock;
    logic          clear;
    logic          clock_enable;
    logic          input_valid;
    logic          input_ready;
    logic [SW-1:0] input_data;
    logic          input_last;
    logic          output_valid;
    logic          output_ready;
    logic [WW-1:0] A;
    logic [WW-1:0] B;
    logic          framing_error;
    logic [1:0]    debug_state;

    int checks = 0;
    int errors = 0;

    wide_operand_loader #(.WORD_WIDTH(WW), .STEP_WORD_WIDTH(SW)) dut (
        .clock         (clock),
        .clear         (clear),
        .clock_enable  (clock_enable),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .input_data    (input_data),
        .input_last    (input_last),
        .output_valid  (output_valid),
        .output_ready  (output_ready),
        .A             (A),
        .B             (B),
        .framing_error (framing_error),
        .debug_state   (debug_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one word for one clock edge; returns 1 time unit after the edge.
    task automatic send(input logic [SW-1:0] data, input logic last);
        input_valid = 1'b1;
        input_data  = data;
        input_last  = last;
        @(posedge clock);
        #1;
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear        = 1'b1;
        clock_enable = 1'b1;
        input_valid  = 1'b0;
        input_data   = '0;
        input_last   = 1'b0;
        output_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        tick();

        // Reset state
        check("reset_valid", 32'(output_valid), 32'd0);
        check("reset_ready", 32'(input_ready), 32'd1);
        check("reset_a", 32'(A), 32'd0);
        check("reset_b", 32'(B), 32'd0);
        check("reset_ferr", 32'(framing_error), 32'd0);
        check("reset_state", 32'(debug_state), 32'd0);

        // Basic pair
        send(8'hDE, 1'b0);
        send(8'hBC, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h45, 1'b0);
        send(8'h23, 1'b0);
        check("basic_not_yet_valid", 32'(output_valid), 32'd0);
        send(8'h01, 1'b1);
        check("basic_valid", 32'(output_valid), 32'd1);
        check("basic_a", 32'(A), 32'hABCDE);
        check("basic_b", 32'(B), 32'h12345);
        check("basic_ferr", 32'(framing_error), 32'd0);
        check("basic_ready_low", 32'(input_ready), 32'd0);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        check("basic_valid_drop", 32'(output_valid), 32'd0);
        check("basic_ready_back", 32'(input_ready), 32'd1);

        // Truncation plus backpressure
        send(8'hDE, 1'b0);
        send(8'hBC, 1'b0);
        send(8'hFA, 1'b0);
        send(8'h45, 1'b0);
        send(8'h23, 1'b0);
        send(8'hF1, 1'b1);
        check("trunc_a", 32'(A), 32'hABCDE);
        check("trunc_b", 32'(B), 32'h12345);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(output_valid), 32'd1);
            check("stall_a", 32'(A), 32'hABCDE);
            check("stall_b", 32'(B), 32'h12345);
            check("stall_ready", 32'(input_ready), 32'd0);
        end
        // output_ready with clock_enable low must not complete the handshake
        clock_enable = 1'b0;
        output_ready = 1'b1;
        tick();
        check("ce_low_valid_hold", 32'(output_valid), 32'd1);
        check("ce_low_ready_hold", 32'(input_ready), 32'd0);
        clock_enable = 1'b1;
        tick();
        output_ready = 1'b0;
        check("bp_valid_drop", 32'(output_valid), 32'd0);
        check("bp_ready_back", 32'(input_ready), 32'd1);

        // Early last
        send(8'hDE, 1'b0);
        send(8'hBC, 1'b1);
        check("early_ferr_pulse", 32'(framing_error), 32'd1);
        check("early_no_valid", 32'(output_valid), 32'd0);
        check("early_state", 32'(debug_state), 32'd0);
        tick();
        check("early_ferr_one_cycle", 32'(framing_error), 32'd0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b1);
        check("early_next_valid", 32'(output_valid), 32'd1);
        check("early_next_a", 32'(A), 32'h32211);
        check("early_next_b", 32'(B), 32'h65544);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;

        // Missing last
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        check("miss_no_valid", 32'(output_valid), 32'd0);
        check("miss_no_ferr_yet", 32'(framing_error), 32'd0);
        check("miss_drain_state", 32'(debug_state), 32'd3);
        check("miss_drain_ready", 32'(input_ready), 32'd1);
        send(8'h07, 1'b0);
        check("miss_no_ferr_7", 32'(framing_error), 32'd0);
        send(8'h08, 1'b1);
        check("miss_ferr_pulse", 32'(framing_error), 32'd1);
        check("miss_still_no_valid", 32'(output_valid), 32'd0);
        tick();
        check("miss_ferr_one_cycle", 32'(framing_error), 32'd0);
        send(8'h78, 1'b0);
        send(8'h56, 1'b0);
        send(8'h34, 1'b0);
        send(8'h21, 1'b0);
        send(8'h43, 1'b0);
        send(8'h65, 1'b1);
        check("miss_next_valid", 32'(output_valid), 32'd1);
        check("miss_next_a", 32'(A), 32'h45678);
        check("miss_next_b", 32'(B), 32'h54321);
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;

        // Asynchronous clear after four words
        send(8'h99, 1'b0);
        send(8'h88, 1'b0);
        send(8'h77, 1'b0);
        send(8'h66, 1'b0);
        #2;
        clear = 1'b1;
        #1;
        check("clr_valid", 32'(output_valid), 32'd0);
        check("clr_ready", 32'(input_ready), 32'd1);
        check("clr_a", 32'(A), 32'd0);
        check("clr_b", 32'(B), 32'd0);
        check("clr_state", 32'(debug_state), 32'd0);
        check("clr_ferr", 32'(framing_error), 32'd0);
        #1;
        clear = 1'b0;
        tick();
        send(8'hDE, 1'b0);
        send(8'hBC, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h45, 1'b0);
        send(8'h23, 1'b0);
        send(8'h01, 1'b1);
        check("clr_next_valid", 32'(output_valid), 32'd1);
        check("clr_next_a", 32'(A), 32'hABCDE);
        check("clr_next_b", 32'(B), 32'h12345);
        check("clr_next_ferr", 32'(framing_error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
